// File: rtl/phase_accum.sv
// Streaming phase generator feeding the complex rotate stage: advances a wide
// phase accumulator per valid sample and emits truncated+offset phase with the sample.
module phase_accum #(
   parameter int DATA_WIDTH  = 16,
   parameter int PHASE_WIDTH = 16,
   parameter int ACC_WIDTH   = 32
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [ACC_WIDTH-1:0]   freq_word,
   input  logic                   freq_load,
   input  logic [PHASE_WIDTH-1:0] phase_offset,
   input  logic                   sync_clr,
   input  logic                   ivalid,
   input  logic [DATA_WIDTH-1:0]  idata_r,
   input  logic [DATA_WIDTH-1:0]  idata_i,
   output logic                   ovalid,
   output logic [PHASE_WIDTH-1:0] phase,
   output logic [DATA_WIDTH-1:0]  odata_r,
   output logic [DATA_WIDTH-1:0]  odata_i
);

   logic [ACC_WIDTH-1:0]   r_inc;
   logic [ACC_WIDTH-1:0]   r_acc;
   logic                   r_s1_valid;
   logic [PHASE_WIDTH-1:0] r_s1_phase;
   logic [DATA_WIDTH-1:0]  r_s1_data_r;
   logic [DATA_WIDTH-1:0]  r_s1_data_i;
   logic                   r_s2_valid;
   logic [PHASE_WIDTH-1:0] r_s2_phase;
   logic [DATA_WIDTH-1:0]  r_s2_data_r;
   logic [DATA_WIDTH-1:0]  r_s2_data_i;

   logic [ACC_WIDTH-1:0]   w_acc_next;
   logic [PHASE_WIDTH-1:0] w_acc_phase;

   // Next accumulator value; a sync clear restarts the sample at zero phase.
   always_comb begin
      w_acc_next  = r_acc;
      w_acc_phase = r_acc[ACC_WIDTH-1 -: PHASE_WIDTH];
      if (sync_clr) begin
         w_acc_phase = {PHASE_WIDTH{1'b0}};
         if (ivalid) begin
            w_acc_next = r_inc;
         end else begin
            w_acc_next = {ACC_WIDTH{1'b0}};
         end
      end else if (ivalid) begin
         w_acc_next = r_acc + r_inc;
      end else begin
         w_acc_next = r_acc;
      end
   end

   // Increment register and accumulator; a coincident load only affects later samples.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_inc <= {ACC_WIDTH{1'b0}};
         r_acc <= {ACC_WIDTH{1'b0}};
      end else begin
         if (freq_load) begin
            r_inc <= freq_word;
         end
         r_acc <= w_acc_next;
      end
   end

   // Stage 1: capture truncated phase and sample data.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_s1_valid  <= 1'b0;
         r_s1_phase  <= {PHASE_WIDTH{1'b0}};
         r_s1_data_r <= {DATA_WIDTH{1'b0}};
         r_s1_data_i <= {DATA_WIDTH{1'b0}};
      end else begin
         r_s1_valid <= ivalid;
         if (ivalid) begin
            r_s1_phase  <= w_acc_phase;
            r_s1_data_r <= idata_r;
            r_s1_data_i <= idata_i;
         end
      end
   end

   // Stage 2: apply static offset; outputs hold their last value between samples.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_s2_valid  <= 1'b0;
         r_s2_phase  <= {PHASE_WIDTH{1'b0}};
         r_s2_data_r <= {DATA_WIDTH{1'b0}};
         r_s2_data_i <= {DATA_WIDTH{1'b0}};
      end else begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_phase  <= r_s1_phase + phase_offset;
            r_s2_data_r <= r_s1_data_r;
            r_s2_data_i <= r_s1_data_i;
         end
      end
   end

   assign ovalid  = r_s2_valid;
   assign phase   = r_s2_phase;
   assign odata_r = r_s2_data_r;
   assign odata_i = r_s2_data_i;

endmodule

// File: tb/tb_phase_accum.sv
// Directed bench for phase_accum: hand-computed phases, latency, hold and
// asynchronous reset behaviour.
module tb_phase_accum;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] freq_word;
   logic        freq_load;
   logic [15:0] phase_offset;
   logic        sync_clr;
   logic        ivalid;
   logic [15:0] idata_r;
   logic [15:0] idata_i;
   logic        ovalid;
   logic [15:0] phase;
   logic [15:0] odata_r;
   logic [15:0] odata_i;

   int tests = 0;
   int fails = 0;

   phase_accum #(.DATA_WIDTH(16), .PHASE_WIDTH(16), .ACC_WIDTH(32)) dut (
      .clock(clock), .reset(reset), .freq_word(freq_word), .freq_load(freq_load),
      .phase_offset(phase_offset), .sync_clr(sync_clr), .ivalid(ivalid),
      .idata_r(idata_r), .idata_i(idata_i), .ovalid(ovalid), .phase(phase),
      .odata_r(odata_r), .odata_i(odata_i)
   );

   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   function automatic logic [15:0] swap(input logic [15:0] d);
      return {d[7:0], d[15:8]};
   endfunction

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Checks the output bundle; imaginary data is the byte-swapped real value.
   task automatic chk(input string tag, input logic ov, input logic [15:0] ph,
                      input logic [15:0] dr);
      cmp({tag, ".ovalid"}, {31'd0, ovalid}, {31'd0, ov});
      cmp({tag, ".phase"}, {16'd0, phase}, {16'd0, ph});
      cmp({tag, ".odata_r"}, {16'd0, odata_r}, {16'd0, dr});
      cmp({tag, ".odata_i"}, {16'd0, odata_i}, {16'd0, swap(dr)});
   endtask

   task automatic cyc(input logic v, input logic [15:0] dr, input logic ld,
                      input logic [31:0] fw, input logic clr);
      ivalid    = v;
      idata_r   = dr;
      idata_i   = swap(dr);
      freq_load = ld;
      freq_word = fw;
      sync_clr  = clr;
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b0; freq_word = 32'd0; freq_load = 1'b0; phase_offset = 16'd0;
      sync_clr = 1'b0; ivalid = 1'b0; idata_r = 16'd0; idata_i = 16'd0;
      #12;
      chk("reset_state", 1'b0, 16'h0000, 16'h0000);
      reset = 1'b1;
      @(posedge clock);
      #1;

      // Basic accumulation
      cyc(1'b0, 16'd0, 1'b1, 32'h40000000, 1'b0); chk("basic_load", 1'b0, 16'h0000, 16'd0);
      cyc(1'b1, 16'd1, 1'b0, 32'd0, 1'b0); chk("basic_lat0", 1'b0, 16'h0000, 16'd0);
      cyc(1'b1, 16'd2, 1'b0, 32'd0, 1'b0); chk("basic_s1", 1'b1, 16'h0000, 16'd1);
      cyc(1'b1, 16'd3, 1'b0, 32'd0, 1'b0); chk("basic_s2", 1'b1, 16'h4000, 16'd2);
      cyc(1'b1, 16'd4, 1'b0, 32'd0, 1'b0); chk("basic_s3", 1'b1, 16'h8000, 16'd3);
      cyc(1'b1, 16'd5, 1'b0, 32'd0, 1'b0); chk("basic_s4", 1'b1, 16'hC000, 16'd4);
      cyc(1'b0, 16'd0, 1'b0, 32'd0, 1'b0); chk("basic_s5", 1'b1, 16'h0000, 16'd5);
      cyc(1'b0, 16'd0, 1'b0, 32'd0, 1'b0); chk("basic_hold", 1'b0, 16'h0000, 16'd5);

      // Gapped input: valids on cycles 0, 3, 4, 9
      cyc(1'b0, 16'd0, 1'b0, 32'd0, 1'b1); chk("gap_clr", 1'b0, 16'h0000, 16'd5);
      cyc(1'b1, 16'd0, 1'b0, 32'd0, 1'b0); chk("gap_k0", 1'b0, 16'h0000, 16'd5);
      cyc(1'b0, 16'd0, 1'b0, 32'd0, 1'b0); chk("gap_k1", 1'b1, 16'h0000, 16'd0);
      cyc(1'b0, 16'd0, 1'b0, 32'd0, 1'b0); chk("gap_k2", 1'b0, 16'h0000, 16'd0);
      cyc(1'b1, 16'd3, 1'b0, 32'd0, 1'b0); chk("gap_k3", 1'b0, 16'h0000, 16'd0);
      cyc(1'b1, 16'd4, 1'b0, 32'd0, 1'b0); chk("gap_k4", 1'b1, 16'h4000, 16'd3);
      cyc(1'b0, 16'd0, 1'b0, 32'd0, 1'b0); chk("gap_k5", 1'b1, 16'h8000, 16'd4);
      cyc(1'b0, 16'd0, 1'b0, 32'd0, 1'b0); chk("gap_k6", 1'b0, 16'h8000, 16'd4);
      cyc(1'b0, 16'd0, 1'b0, 32'd0, 1'b0); chk("gap_k7", 1'b0, 16'h8000, 16'd4);
      cyc(1'b0, 16'd0, 1'b0, 32'd0, 1'b0); chk("gap_k8", 1'b0, 16'h8000, 16'd4);
      cyc(1'b1, 16'd9, 1'b0, 32'd0, 1'b0); chk("gap_k9", 1'b0, 16'h8000, 16'd4);
      cyc(1'b0, 16'd0, 1'b0, 32'd0, 1'b0); chk("gap_k10", 1'b1, 16'hC000, 16'd9);
      cyc(1'b0, 16'd0, 1'b0, 32'd0, 1'b0); chk("gap_k11", 1'b0, 16'hC000, 16'd9);

      // Simultaneous load with the 3rd valid
      cyc(1'b0, 16'd0, 1'b1, 32'h10000000, 1'b1); chk("sim_prep", 1'b0, 16'hC000, 16'd9);
      cyc(1'b1, 16'h11, 1'b0, 32'd0, 1'b0); chk("sim_v1", 1'b0, 16'hC000, 16'd9);
      cyc(1'b1, 16'h12, 1'b0, 32'd0, 1'b0); chk("sim_o1", 1'b1, 16'h0000, 16'h11);
      cyc(1'b1, 16'h13, 1'b1, 32'h20000000, 1'b0); chk("sim_o2", 1'b1, 16'h1000, 16'h12);
      cyc(1'b1, 16'h14, 1'b0, 32'd0, 1'b0); chk("sim_o3", 1'b1, 16'h2000, 16'h13);
      cyc(1'b1, 16'h15, 1'b0, 32'd0, 1'b0); chk("sim_o4", 1'b1, 16'h3000, 16'h14);
      cyc(1'b0, 16'd0, 1'b0, 32'd0, 1'b0); chk("sim_o5", 1'b1, 16'h5000, 16'h15);
      cyc(1'b0, 16'd0, 1'b0, 32'd0, 1'b0); chk("sim_hold", 1'b0, 16'h5000, 16'h15);

      // Offset and negative frequency
      phase_offset = 16'h2000;
      cyc(1'b0, 16'd0, 1'b1, 32'hFFFF0000, 1'b1); chk("neg_prep", 1'b0, 16'h5000, 16'h15);
      cyc(1'b1, 16'h21, 1'b0, 32'd0, 1'b0); chk("neg_v1", 1'b0, 16'h5000, 16'h15);
      cyc(1'b1, 16'h22, 1'b0, 32'd0, 1'b0); chk("neg_o1", 1'b1, 16'h2000, 16'h21);
      cyc(1'b1, 16'h23, 1'b0, 32'd0, 1'b0); chk("neg_o2", 1'b1, 16'h1FFF, 16'h22);
      cyc(1'b0, 16'd0, 1'b0, 32'd0, 1'b0); chk("neg_o3", 1'b1, 16'h1FFE, 16'h23);
      cyc(1'b0, 16'd0, 1'b0, 32'd0, 1'b0); chk("neg_hold", 1'b0, 16'h1FFE, 16'h23);
      phase_offset = 16'h0000;

      // Phase sync with the 4th valid
      cyc(1'b0, 16'd0, 1'b1, 32'h40000000, 1'b1); chk("sync_prep", 1'b0, 16'h1FFE, 16'h23);
      cyc(1'b1, 16'h31, 1'b0, 32'd0, 1'b0); chk("sync_v1", 1'b0, 16'h1FFE, 16'h23);
      cyc(1'b1, 16'h32, 1'b0, 32'd0, 1'b0); chk("sync_o1", 1'b1, 16'h0000, 16'h31);
      cyc(1'b1, 16'h33, 1'b0, 32'd0, 1'b0); chk("sync_o2", 1'b1, 16'h4000, 16'h32);
      cyc(1'b1, 16'h34, 1'b0, 32'd0, 1'b1); chk("sync_o3", 1'b1, 16'h8000, 16'h33);
      cyc(1'b1, 16'h35, 1'b0, 32'd0, 1'b0); chk("sync_o4", 1'b1, 16'h0000, 16'h34);
      cyc(1'b0, 16'd0, 1'b0, 32'd0, 1'b0); chk("sync_o5", 1'b1, 16'h4000, 16'h35);
      cyc(1'b0, 16'd0, 1'b0, 32'd0, 1'b0); chk("sync_hold", 1'b0, 16'h4000, 16'h35);

      // Reset mid-stream
      cyc(1'b1, 16'h41, 1'b0, 32'd0, 1'b0); chk("mid_v1", 1'b0, 16'h4000, 16'h35);
      cyc(1'b1, 16'h42, 1'b0, 32'd0, 1'b0); chk("mid_o1", 1'b1, 16'h8000, 16'h41);
      cyc(1'b1, 16'h43, 1'b0, 32'd0, 1'b0); chk("mid_o2", 1'b1, 16'hC000, 16'h42);
      #3;
      reset = 1'b0;
      #1;
      chk("mid_async", 1'b0, 16'h0000, 16'h0000);
      ivalid = 1'b0;
      @(posedge clock);
      #3;
      reset = 1'b1;
      @(posedge clock);
      #1;
      cyc(1'b1, 16'h51, 1'b0, 32'd0, 1'b0); chk("post_v1", 1'b0, 16'h0000, 16'h0000);
      cyc(1'b1, 16'h52, 1'b0, 32'd0, 1'b0); chk("post_o1", 1'b1, 16'h0000, 16'h51);
      cyc(1'b1, 16'h53, 1'b0, 32'd0, 1'b0); chk("post_o2", 1'b1, 16'h0000, 16'h52);
      cyc(1'b0, 16'd0, 1'b0, 32'd0, 1'b0); chk("post_o3", 1'b1, 16'h0000, 16'h53);
      cyc(1'b0, 16'd0, 1'b0, 32'd0, 1'b0); chk("post_hold", 1'b0, 16'h0000, 16'h53);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
